// File: rtl/granule_pingpong_buffer_if.sv
// Granule stream into the ping-pong buffer and subband stream out of it.
// Latency: none, pure signal bundle.
// Backpressure: dout_rdy only; the input side has no stall path.
interface granule_pingpong_buffer_if #(
  parameter int DW = 32
);
  logic [DW-1:0] ch1_in;
  logic [DW-1:0] ch2_in;
  logic          din_v;
  logic          sync_in;
  logic [1:0]    block_type_in;
  logic          window_switching_flag_in;
  logic          mixed_block_flag_in;
  logic [DW-1:0] ch1_out;
  logic [DW-1:0] ch2_out;
  logic [4:0]    sb_out;
  logic [4:0]    idx_out;
  logic [1:0]    block_type_out;
  logic          window_switching_flag_out;
  logic          mixed_block_flag_out;
  logic          last_out;
  logic          dout_v;
  logic          dout_rdy;

  // Producer/consumer environment side.
  modport master (
    output ch1_in, ch2_in, din_v, sync_in, block_type_in,
           window_switching_flag_in, mixed_block_flag_in, dout_rdy,
    input  ch1_out, ch2_out, sb_out, idx_out, block_type_out,
           window_switching_flag_out, mixed_block_flag_out, last_out, dout_v
  );

  // Buffer side.
  modport slave (
    input  ch1_in, ch2_in, din_v, sync_in, block_type_in,
           window_switching_flag_in, mixed_block_flag_in, dout_rdy,
    output ch1_out, ch2_out, sb_out, idx_out, block_type_out,
           window_switching_flag_out, mixed_block_flag_out, last_out, dout_v
  );
endinterface

// File: rtl/granule_pingpong_buffer.sv
// Two-bank granule store: serial 576-sample stereo granules in, 32x18 subband replay out.
// Latency: last write in cycle T -> first dout_v in T+2; <=2 bubbles between full banks.
// Backpressure: outputs hold while dout_v && !dout_rdy; input never stalls, a granule with no free bank is dropped (overflow). GPB_DROP_CNT_EN adds drop_cnt.
module granule_pingpong_buffer #(
  parameter int DW     = 32,
  parameter int GR_LEN = 576
) (
  input  logic                    clk,
  input  logic                    rst,
  granule_pingpong_buffer_if.slave bus,
  output logic                    overflow
`ifdef GPB_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);
  localparam int CW = $clog2(GR_LEN + 1);
  localparam int AW = $clog2(2 * GR_LEN);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;
  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wr_st_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_st_t;
  typedef struct packed {
    logic [1:0] bt;
    logic       wsf;
    logic       mbf;
  } side_t;

  logic [2*DW-1:0] r_mem [2*GR_LEN];
  bank_st_t        r_bank_st [2];
  bank_st_t        w_bank_st [2];
  side_t           r_side [2];
  side_t           w_side_in;

  wr_st_t          r_wr_st, w_wr_st;
  logic [CW-1:0]   r_wr_cnt, w_wr_cnt;
  logic            r_wr_bank, w_wr_bank;
  logic            w_we, w_ovf, w_wr_start, w_wr_full, w_wr_abort;
  logic [AW-1:0]   w_wr_addr;

  rd_st_t          r_rd_st, w_rd_st;
  logic [CW-1:0]   r_rd_cnt, w_rd_cnt;
  logic            r_rd_bank, w_rd_bank;
  logic            w_rd_start, w_rd_done, w_load;
  logic [AW-1:0]   w_rd_addr;

  logic [DW-1:0]   r_ch1, r_ch2;
  logic [4:0]      r_sb, r_idx;
  side_t           r_side_out;
  logic            r_last, r_dout_v, r_overflow;

  assign w_side_in = {bus.block_type_in, bus.window_switching_flag_in, bus.mixed_block_flag_in};
  assign w_wr_addr = r_wr_bank ? AW'(GR_LEN) + AW'(r_wr_cnt) : AW'(r_wr_cnt);
  assign w_rd_addr = r_rd_bank ? AW'(GR_LEN) + AW'(r_rd_cnt) : AW'(r_rd_cnt);

  // Write FSM next state: sync aborts everything, otherwise each din_v advances fill or drop count.
  always_comb begin
    w_wr_st    = r_wr_st;
    w_wr_cnt   = r_wr_cnt;
    w_wr_bank  = r_wr_bank;
    w_we       = 1'b0;
    w_ovf      = 1'b0;
    w_wr_start = 1'b0;
    w_wr_full  = 1'b0;
    w_wr_abort = 1'b0;
    if (bus.sync_in) begin
      w_wr_st    = W_IDLE;
      w_wr_cnt   = '0;
      w_wr_abort = 1'b1;
    end else if (bus.din_v) begin
      case (r_wr_st)
        W_IDLE: begin
          w_wr_cnt = CW'(1);
          if (r_bank_st[r_wr_bank] == B_EMPTY) begin
            w_we       = 1'b1;
            w_wr_start = 1'b1;
            w_wr_st    = W_WRITE;
          end else begin
            w_ovf   = 1'b1;
            w_wr_st = W_DROP;
          end
        end
        W_WRITE: begin
          w_we = 1'b1;
          if (r_wr_cnt == CW'(GR_LEN - 1)) begin
            w_wr_full = 1'b1;
            w_wr_bank = ~r_wr_bank;
            w_wr_cnt  = '0;
            w_wr_st   = W_IDLE;
          end else begin
            w_wr_cnt = r_wr_cnt + CW'(1);
          end
        end
        W_DROP: begin
          if (r_wr_cnt == CW'(GR_LEN - 1)) begin
            w_wr_cnt = '0;
            w_wr_st  = W_IDLE;
          end else begin
            w_wr_cnt = r_wr_cnt + CW'(1);
          end
        end
        default: w_wr_st = W_IDLE;
      endcase
    end
  end

  // Read FSM next state: start a FULL bank, then fetch one sample per completed transfer.
  always_comb begin
    w_rd_st    = r_rd_st;
    w_rd_cnt   = r_rd_cnt;
    w_rd_bank  = r_rd_bank;
    w_rd_start = 1'b0;
    w_rd_done  = 1'b0;
    w_load     = 1'b0;
    case (r_rd_st)
      R_IDLE: begin
        if (r_bank_st[r_rd_bank] == B_FULL) begin
          w_rd_start = 1'b1;
          w_rd_cnt   = CW'(1);
          w_rd_st    = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (r_dout_v && bus.dout_rdy) begin
          if (r_last) begin
            w_rd_done = 1'b1;
            w_rd_bank = ~r_rd_bank;
            w_rd_cnt  = '0;
            w_rd_st   = R_IDLE;
          end else begin
            w_load   = 1'b1;
            w_rd_cnt = r_rd_cnt + CW'(1);
          end
        end
      end
      default: w_rd_st = R_IDLE;
    endcase
  end

  // Bank states: write and read events always target different banks, so both apply in one cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) w_bank_st[b] = r_bank_st[b];
    if (w_wr_start) w_bank_st[r_wr_bank] = B_FILLING;
    if (w_wr_full)  w_bank_st[r_wr_bank] = B_FULL;
    if (w_wr_abort && r_bank_st[r_wr_bank] == B_FILLING) w_bank_st[r_wr_bank] = B_EMPTY;
    if (w_rd_start) w_bank_st[r_rd_bank] = B_DRAINING;
    if (w_rd_done)  w_bank_st[r_rd_bank] = B_EMPTY;
  end

  // Sample storage, no reset needed: a bank is only read after being fully written.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wr_addr] <= {bus.ch1_in, bus.ch2_in};
  end

  // Control state registers and side-info capture on the first sample of a granule.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_st      <= W_IDLE;
      r_wr_cnt     <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_st      <= R_IDLE;
      r_rd_cnt     <= '0;
      r_rd_bank    <= 1'b0;
      r_bank_st[0] <= B_EMPTY;
      r_bank_st[1] <= B_EMPTY;
      r_side[0]    <= '0;
      r_side[1]    <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_wr_st      <= w_wr_st;
      r_wr_cnt     <= w_wr_cnt;
      r_wr_bank    <= w_wr_bank;
      r_rd_st      <= w_rd_st;
      r_rd_cnt     <= w_rd_cnt;
      r_rd_bank    <= w_rd_bank;
      r_bank_st[0] <= w_bank_st[0];
      r_bank_st[1] <= w_bank_st[1];
      if (w_wr_start) r_side[r_wr_bank] <= w_side_in;
      r_overflow   <= w_ovf;
    end
  end

  // Output register doubles as the RAM read stage; it only moves on start or completed transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ch1      <= '0;
      r_ch2      <= '0;
      r_sb       <= '0;
      r_idx      <= '0;
      r_side_out <= '0;
      r_last     <= 1'b0;
      r_dout_v   <= 1'b0;
    end else if (w_rd_start) begin
      {r_ch1, r_ch2} <= r_mem[w_rd_addr];
      r_sb       <= '0;
      r_idx      <= '0;
      r_side_out <= r_side[r_rd_bank];
      r_last     <= 1'b0;
      r_dout_v   <= 1'b1;
    end else if (w_load) begin
      {r_ch1, r_ch2} <= r_mem[w_rd_addr];
      if (r_idx == 5'd17) begin
        r_idx <= '0;
        r_sb  <= r_sb + 5'd1;
      end else begin
        r_idx <= r_idx + 5'd1;
      end
      r_last <= (r_rd_cnt == CW'(GR_LEN - 1));
    end else if (w_rd_done) begin
      r_last   <= 1'b0;
      r_dout_v <= 1'b0;
    end
  end

`ifdef GPB_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating count of dropped granules, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_ovf && r_drop_cnt != 8'hFF) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
`endif

  assign bus.ch1_out                   = r_ch1;
  assign bus.ch2_out                   = r_ch2;
  assign bus.sb_out                    = r_sb;
  assign bus.idx_out                   = r_idx;
  assign bus.block_type_out            = r_side_out.bt;
  assign bus.window_switching_flag_out = r_side_out.wsf;
  assign bus.mixed_block_flag_out      = r_side_out.mbf;
  assign bus.last_out                  = r_last;
  assign bus.dout_v                    = r_dout_v;
  assign overflow                      = r_overflow;
endmodule

// File: tb/tb_granule_pingpong_buffer.sv
// Directed bench for the granule ping-pong buffer with a scoreboard of expected outputs.
// Latency: checks first dout_v two cycles after the last write.
// Backpressure: drives held-low, always-high and random dout_rdy and checks output hold.
module tb_granule_pingpong_buffer;
  localparam int DW = 32;
  localparam int GR = 576;

  logic clk;
  logic rst;
  logic overflow;
  logic tb_rdy;
  logic rnd_rdy;
  logic rnd_en;
`ifdef GPB_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  granule_pingpong_buffer_if #(.DW(DW)) bus_if ();

  granule_pingpong_buffer #(.DW(DW), .GR_LEN(GR)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .overflow (overflow)
`ifdef GPB_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  assign bus_if.dout_rdy = rnd_en ? rnd_rdy : tb_rdy;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int rise_cyc = 0;
  int mon_cnt = 0;
  int mon_last = 0;
  int ovf_cnt = 0;
  int max_gap = 0;
  int gap_run = 0;
  bit gap_arm = 0;
  bit gap_seen = 0;
  bit prev_stall = 0;
  bit prev_v = 0;
  logic [79:0] prev_val;
  logic [79:0] cur;
  logic [79:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    rnd_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  function automatic logic [79:0] pack_out();
    return {bus_if.ch1_out, bus_if.ch2_out, bus_if.sb_out, bus_if.idx_out, bus_if.last_out,
            bus_if.block_type_out, bus_if.window_switching_flag_out,
            bus_if.mixed_block_flag_out, bus_if.dout_v};
  endfunction

  function automatic logic [79:0] mk_exp(input int base, input int i, input logic [1:0] bt,
                                         input logic wsf, input logic mbf);
    logic [31:0] v;
    v = 32'(base + i);
    return {v, -v, 5'(i / 18), 5'(i % 18), (i == GR - 1), bt, wsf, mbf, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int base, input int n, input logic [1:0] bt, input logic wsf,
                      input logic mbf, input bit gap, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      bus_if.ch1_in = 32'(base + i);
      bus_if.ch2_in = -32'(base + i);
      bus_if.block_type_in = bt;
      bus_if.window_switching_flag_in = wsf;
      bus_if.mixed_block_flag_in = mbf;
      bus_if.din_v = 1'b1;
      if (expect_out) exp_q.push_back(mk_exp(base, i, bt, wsf, mbf));
      if (i == n - 1) last_wr_cyc = cyc;
      tick();
      if (gap && (i % 4 == 3)) begin
        bus_if.din_v = 1'b0;
        tick();
      end
    end
    bus_if.din_v = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 80'(exp_q.size()), 80'(0));
    repeat (8) tick();
  endtask

  // Output monitor: scoreboard compare, stall-hold check, overflow and bubble tracking.
  initial begin
    forever begin
      @(negedge clk);
      cur = pack_out();
      if (!rst) begin
        prev_stall = 0;
        prev_v = 0;
      end else begin
        if (prev_stall) chk("hold", cur, prev_val);
        if (bus_if.dout_v && !prev_v) rise_cyc = cyc;
        if (overflow) ovf_cnt++;
        if (gap_arm) begin
          if (bus_if.dout_v) begin
            gap_run = 0;
            gap_seen = 1;
          end else if (gap_seen && exp_q.size() > 0) begin
            gap_run++;
            if (gap_run > max_gap) max_gap = gap_run;
          end
        end
        if (bus_if.dout_v && bus_if.dout_rdy) begin
          if (exp_q.size() > 0) chk($sformatf("sample%0d", mon_cnt), cur, exp_q.pop_front());
          mon_cnt++;
          if (bus_if.last_out) mon_last++;
        end
        prev_stall = bus_if.dout_v && !bus_if.dout_rdy;
        prev_v = bus_if.dout_v;
        prev_val = cur;
      end
    end
  end

  initial begin
    int m0;
    int n;
    rst = 1'b0;
    rnd_en = 1'b0;
    tb_rdy = 1'b1;
    bus_if.ch1_in = '0;
    bus_if.ch2_in = '0;
    bus_if.din_v = 1'b0;
    bus_if.sync_in = 1'b0;
    bus_if.block_type_in = '0;
    bus_if.window_switching_flag_in = 1'b0;
    bus_if.mixed_block_flag_in = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_outputs", pack_out(), 80'(0));
    chk("rst_overflow", 80'(overflow), 80'(0));
`ifdef GPB_DROP_CNT_EN
    chk("rst_drop_cnt", 80'(drop_cnt), 80'(0));
`endif
    rst = 1'b1;
    tick();

    // Single ramp granule, block_type 2, ready always high
    m0 = mon_cnt;
    n = mon_last;
    send(0, GR, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain("single_drain", 1500);
    chk("single_latency", 80'(rise_cyc - last_wr_cyc), 80'(2));
    chk("single_count", 80'(mon_cnt - m0), 80'(GR));
    chk("single_last_cnt", 80'(mon_last - n), 80'(1));

    // Two back-to-back granules: bubbles at the boundary and side info switch
    m0 = mon_cnt;
    max_gap = 0;
    gap_run = 0;
    gap_seen = 0;
    gap_arm = 1;
    send(1000, GR, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    send(5000, GR, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain("b2b_drain", 2500);
    gap_arm = 0;
    chk("b2b_count", 80'(mon_cnt - m0), 80'(2 * GR));
    chk("b2b_gap_le2", 80'(max_gap <= 2), 80'(1));
    chk("b2b_gap_seen", 80'(gap_seen), 80'(1));

    // Ready held low: two banks fill, third granule overflows and is dropped
    m0 = mon_cnt;
    ovf_cnt = 0;
    tb_rdy = 1'b0;
    send(7000, GR, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    send(8000, GR, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    send(9000, GR, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    chk("stall_ovf_once", 80'(ovf_cnt), 80'(1));
    chk("stall_no_output", 80'(mon_cnt - m0), 80'(0));
    chk("stall_dout_v_held", 80'(bus_if.dout_v), 80'(1));
    tb_rdy = 1'b1;
    wait_drain("stall_drain", 2500);
    chk("stall_count", 80'(mon_cnt - m0), 80'(2 * GR));
    chk("stall_ovf_total", 80'(ovf_cnt), 80'(1));
`ifdef GPB_DROP_CNT_EN
    chk("stall_drop_cnt", 80'(drop_cnt), 80'(1));
`endif

    // Random ready with a gapped input stream
    m0 = mon_cnt;
    ovf_cnt = 0;
    rnd_en = 1'b1;
    send(11000, GR, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    send(12000, GR, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_drain("rand_drain", 6000);
    rnd_en = 1'b0;
    tb_rdy = 1'b1;
    chk("rand_count", 80'(mon_cnt - m0), 80'(2 * GR));
    chk("rand_no_ovf", 80'(ovf_cnt), 80'(0));

    // Sync after 300 samples (coincident sample discarded), then a full granule
    m0 = mon_cnt;
    send(20000, 300, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_if.ch1_in = 32'hDEAD;
    bus_if.ch2_in = 32'hBEEF;
    bus_if.din_v = 1'b1;
    bus_if.sync_in = 1'b1;
    tick();
    bus_if.sync_in = 1'b0;
    bus_if.din_v = 1'b0;
    send(30000, GR, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("sync_drain", 1500);
    chk("sync_count", 80'(mon_cnt - m0), 80'(GR));

    // Reset in the middle of a drain at sample 100
    m0 = mon_cnt;
    send(40000, GR, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (mon_cnt - m0 < 100 && n < 1500) begin
      tick();
      n++;
    end
    chk("mid_reached", 80'(mon_cnt - m0), 80'(100));
    chk("mid_sb", 80'(bus_if.sb_out), 80'(5));
    chk("mid_idx", 80'(bus_if.idx_out), 80'(10));
    chk("mid_ch1", 80'(bus_if.ch1_out), 80'(40100));
    rst = 1'b0;
    tick();
    chk("mid_rst_outputs", pack_out(), 80'(0));
    chk("mid_rst_overflow", 80'(overflow), 80'(0));
    exp_q.delete();
    rst = 1'b1;
    tick();
    m0 = mon_cnt;
    send(50000, GR, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain("post_rst_drain", 1500);
    chk("post_rst_count", 80'(mon_cnt - m0), 80'(GR));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/granule_pingpong_buffer.md
# granule_pingpong_buffer

Double-buffered granule store between the antialias reorder stage and the IMDCT. Accepts the serial, frequency-ordered stream of 576 stereo samples per granule, with no backpressure on the input side. Replays each completed granule to the IMDCT as 32 subbands × 18 samples under a valid/ready handshake. Two banks let granule N+1 be written while granule N is drained.

## Interface
Parameters:
- `DW`, 32: sample width, signed fixed-point, passed through unmodified.
- `GR_LEN`, 576: samples per granule. Must be a multiple of 18.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `ch1_in`  in  DW  channel 1 sample.
- `ch2_in`  in  DW  channel 2 sample.
- `din_v`  in  1  input sample valid; may have gaps; never stalled.
- `sync_in`  in  1  resync pulse; aborts any partially written granule.
- `block_type_in`  in  2  granule side info, sampled with the first sample of a granule.
- `window_switching_flag_in`  in  1  as above.
- `mixed_block_flag_in`  in  1  as above.
- `ch1_out`, `ch2_out`  out  DW  buffered samples.
- `sb_out`  out  5  subband index, 0..31.
- `idx_out`  out  5  sample index within the subband, 0..17.
- `block_type_out`, `window_switching_flag_out`, `mixed_block_flag_out`  out  2/1/1  side info of the granule being drained.
- `last_out`  out  1  high on sample 575 of the granule.
- `dout_v`  out  1  output valid.
- `dout_rdy`  in  1  consumer ready.
- `overflow`  out  1  one-cycle pulse when a granule is dropped.
- `drop_cnt`  out  8  saturating count of dropped granules. Present only with `GPB_DROP_CNT_EN`.

## Operation
- Storage: two banks, each `GR_LEN` × 2·DW. Each bank has a per-bank state EMPTY/FILLING/FULL/DRAINING and a latched side-info record.
- Write FSM, states IDLE, WRITE, DROP. `wr_cnt` runs 0..575.
  - IDLE: on `din_v`, if the write bank is EMPTY, write address 0, latch side info, set the bank to FILLING, go to WRITE.
  - IDLE: on `din_v`, if the write bank is not EMPTY, pulse `overflow` and go to DROP.
  - WRITE: each `din_v` writes address `wr_cnt`. On address 575: set the bank to FULL, toggle the write bank, return to IDLE.
  - DROP: count `din_v` samples to 576 without writing, then return to IDLE. The write bank is unchanged.
- `sync_in`: forces the write FSM to IDLE and `wr_cnt` to 0.
  - A FILLING bank returns to EMPTY.
  - FULL and DRAINING banks are untouched.
  - `sync_in` takes priority over a coincident `din_v`; that sample is discarded.
- Read FSM, states IDLE, DRAIN. `rd_cnt` runs 0..575.
  - IDLE: when the read bank is FULL, set it to DRAINING and go to DRAIN.
  - DRAIN: `sb_out = rd_cnt / 18`, `idx_out = rd_cnt % 18`, both maintained as counters (no divider).
  - A sample completes on `dout_v && dout_rdy`.
  - After sample 575 completes: the bank becomes EMPTY, the read bank toggles, and the FSM returns to IDLE.
- Simultaneous events:
  - A write bank going FULL and the read side freeing the other bank in the same cycle are both honoured.
  - A bank freed in cycle T is writable in cycle T+1.

## Timing
- Reset values:
  - All outputs 0.
  - Both banks EMPTY; write bank = read bank = 0.
  - Both FSMs IDLE; `drop_cnt` = 0.
- Latency: 576th sample written in cycle T → `dout_v` = 1 in cycle T+2 (one cycle bank-state update, one cycle RAM read).
- Throughput: one sample per cycle while `dout_rdy` is held high, including across the granule boundary when the other bank is already FULL. That boundary has at most 2 bubble cycles.
- Handshake:
  - While `dout_v && !dout_rdy`, all outputs hold stable.
  - `dout_v` never drops without a completed transfer, except on reset.
- Reset mid-operation: both granules are discarded and state returns to the reset values on the next edge.

## Configuration
- `GPB_DROP_CNT_EN` defined:
  - Adds port `drop_cnt`.
  - Increments on each `overflow` pulse, saturating at 255.
  - Cleared only by `rst`.
- Not defined: port and counter are absent; `overflow` behaviour is identical.

## Test plan
- Single granule, ramp data `ch1 = i`, `ch2 = -i`, `block_type_in = 2`, `dout_rdy` = 1 → 576 outputs in order:
  - `sb_out`/`idx_out` step 0/0 … 31/17.
  - `last_out` only on sample 575.
  - `block_type_out` = 2.
  - First `dout_v` exactly 2 cycles after the last write.
- Two back-to-back granules with `dout_rdy` = 1 → 1152 outputs, at most 2 idle cycles between granules, and side info switches at `sb_out` = 0.
- `dout_rdy` held low → granules 1 and 2 fill both banks; granule 3 raises `overflow` once and is dropped. After release, exactly 1152 samples emerge and `drop_cnt` = 1 with the macro defined.
- Random `dout_rdy` at 50% duty with a gapped input → output sequence matches the input sequence bit-exactly, and data holds stable while stalled.
- `sync_in` after 300 samples, then a full granule → only the 576 post-sync samples are output.
- `rst` low during a drain at sample 100 → next cycle all outputs are 0; a subsequent granule drains normally from `sb_out` = 0.
